// File: rtl/extreme_slot_buffer.sv
// Slot pool feeding an external binary-tree min/max finder. Empty slots show a sentinel that never
// wins, and the finder's combinational result is popped and retires its lowest-index matching slot.
module extreme_slot_cell #(
    parameter int data_sz = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               set_i,
    input  logic               clr_i,
    input  logic [data_sz-1:0] data_i,
    output logic               valid_o,
    output logic [data_sz-1:0] data_o
);
    logic               v_q, v_d;
    logic [data_sz-1:0] data_q, data_d;

    // set and clr never target the same slot: set picks an empty slot, clr an occupied one
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush_i) begin
            v_d = 1'b0;
        end else begin
            if (clr_i) v_d = 1'b0;
            if (set_i) begin
                v_d    = 1'b1;
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign valid_o = v_q;
    assign data_o  = data_q;
endmodule

module extreme_slot_buffer #(
    parameter int level      = 3,
    parameter int data_sz    = 4,
    parameter int comparator = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [data_sz-1:0]                     in_data,
    output logic [(1<<(level-1))*data_sz-1:0]      raw_out,
    input  logic [data_sz-1:0]                     ext_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [data_sz-1:0]                     out_data,
    output logic [level-1:0]                       count,
    output logic                                   full,
    output logic                                   empty
);
    localparam int N = 1 << (level - 1);
    localparam logic [data_sz-1:0] SENT = (comparator != 0) ? '0 : '1;

    logic [N-1:0]              slot_v;
    logic [N-1:0][data_sz-1:0] slot_d;
    logic [N-1:0]              set_vec, clr_vec;
    logic                      found_free, found_match;
    logic                      push, pop_req, pop_hit;
    logic [level-1:0]          count_q, count_d;

    assign full      = (count_q == level'(N));
    assign empty     = (count_q == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign out_data  = ext_in;
    assign count     = count_q;

    assign push    = in_valid & in_ready;
    assign pop_req = out_valid & out_ready;
    assign pop_hit = pop_req & found_match;

    // Both selections use pre-pop slot_v, so a slot freed this cycle is only reusable next cycle
    always_comb begin
        set_vec     = '0;
        clr_vec     = '0;
        found_free  = 1'b0;
        found_match = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!slot_v[i] && !found_free) begin
                found_free = 1'b1;
                set_vec[i] = push;
            end
            if (slot_v[i] && (slot_d[i] == ext_in) && !found_match) begin
                found_match = 1'b1;
                clr_vec[i]  = pop_req;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush)
            count_d = '0;
        else if (push && !pop_hit)
            count_d = count_q + level'(1);
        else if (!push && pop_hit)
            count_d = count_q - level'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    for (genvar g = 0; g < N; g++) begin : g_slot
        extreme_slot_cell #(.data_sz(data_sz)) u_cell (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .set_i   (set_vec[g]),
            .clr_i   (clr_vec[g]),
            .data_i  (in_data),
            .valid_o (slot_v[g]),
            .data_o  (slot_d[g])
        );
        assign raw_out[g*data_sz +: data_sz] = slot_v[g] ? slot_d[g] : SENT;
    end
endmodule
